maxpool_sequencer: RTL and testbench
====================================

Name: maxpool_sequencer

Overview:
- Per-layer controller in front of the maxpool engine.
- Accepts one layer configuration: pooling window length in beats, and number of windows.
- Forwards the conv output stream to the maxpool engine through a one-deep registered stage.
- Tags every forwarded beat with the engine's tuser flags and frames the layer with a last pulse.

Parameters:
- UNITS, 2, units per group; sets data width.
- GROUPS, 2, cores; sets data width.
- WORD_WIDTH, 8, bits per word.
- POOL_MAX, 9, maximum beats per pooling window.
- WIN_WIDTH, 16, width of the window-count field.
- I_IS_NOT_MAX, 0, tuser bit index: beat is not the last of its window.
- I_IS_MAX, 1, tuser bit index: beat closes its window.
- I_IS_1X1, 2, tuser bit index: no pooling (window length 1).

Ports:
- clk  in  1  clock.
- clken  in  1  global clock enable; when low, all state holds.
- resetn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  high in IDLE only.
- cfg_pool_len  in  $clog2(POOL_MAX+1)  beats per window.
- cfg_windows  in  WIN_WIDTH  windows in the layer.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted.
- s_data  in  GROUPS*UNITS*2*WORD_WIDTH  input beat.
- m_valid  out  1  to engine s_valid.
- m_ready  in  1  from engine s_ready.
- m_data  out  GROUPS*UNITS*2*WORD_WIDTH  to engine.
- m_user  out  I_IS_1X1+1  to engine s_user.
- m_last  out  1  last beat of the layer.
- busy  out  1  state != IDLE.
- err_cfg  out  1  sticky; illegal configuration was rejected.

Behaviour:
- Reset values: state=IDLE; m_valid=0, m_last=0, m_user=0, m_data=0, err_cfg=0, busy=0. All counters are 0.
- States: IDLE, RUN, DRAIN. All transitions are qualified by clken.
- IDLE:
  - cfg_ready=1, s_ready=0.
  - On cfg_valid, if cfg_pool_len is in 1..POOL_MAX and cfg_windows is nonzero: latch both values, clear beat_cnt and win_cnt, go to RUN.
  - Otherwise set err_cfg=1 and stay in IDLE.
  - err_cfg clears only on reset.
- RUN:
  - s_ready = !m_valid || m_ready (full-throughput register slice).
  - On an s_valid && s_ready handshake:
    - Load m_data and m_valid=1.
    - m_user is all zeros except exactly one set bit:
      - I_IS_1X1 if pool_len==1.
      - Else I_IS_MAX if beat_cnt==pool_len-1.
      - Else I_IS_NOT_MAX.
    - m_last=1 iff the beat closes the window and win_cnt==windows-1.
    - beat_cnt increments, wrapping to 0 at pool_len-1. win_cnt increments on that wrap.
  - After the m_last beat is loaded, go to DRAIN. s_ready drops on the next cycle.
- DRAIN:
  - s_ready=0.
  - When m_valid && m_ready: go to IDLE.
- Output register:
  - m_valid && m_ready with no new input clears m_valid, m_last and m_user.
  - m_valid held with !m_ready keeps m_data, m_user and m_last stable.
  - Simultaneous drain and load in the same cycle passes the new beat with no bubble.
- Latency: 1 cycle from s handshake to m_valid. Throughput: 1 beat/cycle while m_ready=1.
- clken=0: all registers hold. Outputs remain combinationally consistent.
- Asynchronous reset mid-layer:
  - Returns immediately to the reset values.
  - Any in-flight beat is dropped.
  - The next layer requires a fresh configuration.
- Counters are sized $clog2(POOL_MAX) and WIN_WIDTH. No overflow is possible given the configuration checks.

Test Plan:
- pool_len=2, windows=3, 6 beats, m_ready=1:
  - m_user one-hot sequence: NOT_MAX, MAX, NOT_MAX, MAX, NOT_MAX, MAX.
  - m_last only on beat 6.
  - busy falls 1 cycle after beat 6 drains.
  - cfg_ready returns.
- pool_len=1, windows=4:
  - All 4 beats carry I_IS_1X1 only.
  - m_last on beat 4.
  - Back-to-back with no bubbles.
- pool_len=3, windows=2, m_ready toggled 1/0 each cycle:
  - No beat lost or duplicated.
  - Data order preserved.
  - Outputs stable while stalled.
  - MAX on beats 3 and 6.
- Illegal configurations, each offered in IDLE with nothing else in between: cfg_pool_len=0, then cfg_pool_len=POOL_MAX+1, then cfg_windows=0:
  - err_cfg rises after the first bad offer and stays high.
  - Stays in IDLE throughout; s_ready=0.
- Assert resetn low after 3 beats of a pool_len=2, windows=4 layer:
  - m_valid=0 immediately; state IDLE.
  - A new configuration with windows=1, pool_len=2 produces NOT_MAX then MAX+last.
- clken=0 for 5 cycles mid-layer with s_valid=1:
  - Nothing advances.
  - Sequence resumes exactly where it stopped.

Source files
------------

// File: rtl/maxpool_sequencer.sv
// Per-layer sequencer in front of the maxpool engine: accepts one layer
// configuration, forwards the conv stream through a one-deep register slice,
// tags each beat with the engine's window flags and marks the layer's last beat.
module maxpool_sequencer #(
  parameter int UNITS        = 2,
  parameter int GROUPS       = 2,
  parameter int WORD_WIDTH   = 8,
  parameter int POOL_MAX     = 9,
  parameter int WIN_WIDTH    = 16,
  parameter int I_IS_NOT_MAX = 0,
  parameter int I_IS_MAX     = 1,
  parameter int I_IS_1X1     = 2
) (
  input  logic                                  clk,
  input  logic                                  clken,
  input  logic                                  resetn,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [$clog2(POOL_MAX+1)-1:0]         cfg_pool_len,
  input  logic [WIN_WIDTH-1:0]                  cfg_windows,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [GROUPS*UNITS*2*WORD_WIDTH-1:0]  s_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [GROUPS*UNITS*2*WORD_WIDTH-1:0]  m_data,
  output logic [I_IS_1X1:0]                     m_user,
  output logic                                  m_last,
  output logic                                  busy,
  output logic                                  err_cfg
);

  localparam int PLW = $clog2(POOL_MAX+1);
  localparam int CW  = (POOL_MAX > 1) ? $clog2(POOL_MAX) : 1;
  localparam int UW  = I_IS_1X1 + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state;
  logic [PLW-1:0]       pool_len;
  logic [WIN_WIDTH-1:0] windows;
  logic [WIN_WIDTH-1:0] win_cnt;
  logic [CW-1:0]        beat_cnt;

  logic                 take;
  logic                 drain;
  logic                 win_close;
  logic                 layer_end;
  logic                 cfg_ok;
  logic [UW-1:0]        user_next;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // s_ready is gated by clken so upstream never sees a handshake the slice ignores
  assign s_ready   = clken && (state == RUN) && (!m_valid || m_ready);
  assign take      = s_valid && s_ready;
  assign drain     = m_valid && m_ready;
  assign win_close = (PLW'(beat_cnt) == pool_len - PLW'(1));
  assign layer_end = win_close && (win_cnt == windows - WIN_WIDTH'(1));
  assign cfg_ok    = (cfg_pool_len != '0) && (cfg_pool_len <= PLW'(POOL_MAX)) &&
                     (cfg_windows != '0);

  // One-hot window flag for the beat being accepted
  always_comb begin
    user_next = '0;
    if (pool_len == PLW'(1))
      user_next[I_IS_1X1] = 1'b1;
    else if (win_close)
      user_next[I_IS_MAX] = 1'b1;
    else
      user_next[I_IS_NOT_MAX] = 1'b1;
  end

  // Layer FSM, window/beat counters and the registered output slice
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      pool_len <= '0;
      windows  <= '0;
      win_cnt  <= '0;
      beat_cnt <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_user   <= '0;
      m_last   <= 1'b0;
      err_cfg  <= 1'b0;
    end else if (clken) begin
      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_ok) begin
              pool_len <= cfg_pool_len;
              windows  <= cfg_windows;
              beat_cnt <= '0;
              win_cnt  <= '0;
              state    <= RUN;
            end else begin
              err_cfg  <= 1'b1;
            end
          end
        end
        RUN: begin
          // A drain followed by a load in the same cycle leaves the new beat in place
          if (drain) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_user  <= '0;
          end
          if (take) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_user  <= user_next;
            m_last  <= layer_end;
            if (win_close) begin
              beat_cnt <= '0;
              win_cnt  <= win_cnt + WIN_WIDTH'(1);
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
            if (layer_end)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_user  <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_sequencer.sv
// Randomized bench for maxpool_sequencer against a window-arithmetic reference model.
module tb_maxpool_sequencer;

  localparam int POOL_MAX = 9;
  localparam int DW       = 64;
  localparam int PLW      = $clog2(POOL_MAX+1);

  logic            clk = 1'b0;
  logic            clken;
  logic            resetn;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [PLW-1:0]  cfg_pool_len;
  logic [15:0]     cfg_windows;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [2:0]      m_user;
  logic            m_last;
  logic            busy;
  logic            err_cfg;

  maxpool_sequencer #(.POOL_MAX(POOL_MAX)) dut (
    .clk(clk), .clken(clken), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pool_len(cfg_pool_len), .cfg_windows(cfg_windows),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_user(m_user), .m_last(m_last), .busy(busy), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [2:0]    u;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Per-cycle stimulus for each traffic pattern
  task automatic drive(input int mode, input int cyc);
    s_data = {$urandom, $urandom};
    clken  = 1'b1;
    case (mode)
      0: begin s_valid = 1'b1; m_ready = 1'b1; end
      1: begin s_valid = 1'b1; m_ready = (cyc % 2 == 0); end
      2: begin s_valid = ($urandom_range(0, 3) != 0); m_ready = ($urandom_range(0, 2) != 0); end
      default: begin
        s_valid = 1'b1; m_ready = 1'b1;
        clken   = !(cyc >= 4 && cyc < 9);
      end
    endcase
  endtask

  // Runs one layer; abort_at>0 stops right after that many beats were accepted
  task automatic run_layer(input int p, input int w, input int mode, input int abort_at);
    int    total = p * w;
    int    acc = 0;
    int    pop = 0;
    int    cyc = 0;
    bit    done = 0;
    bit    exp_sready;
    beat_t b;
    exp_q.delete();
    @(negedge clk);
    cfg_pool_len = PLW'(p);
    cfg_windows  = 16'(w);
    cfg_valid    = 1'b1;
    check("cfg_ready_idle", cfg_ready, 1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    drive(mode, 0);
    while (!done) begin
      @(negedge clk);
      exp_sready = clken && (acc < total) && (exp_q.size() == 0 || m_ready);
      check("s_ready", s_ready, exp_sready);
      check("m_valid", m_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("m_data", m_data, exp_q[0].d);
        check("m_user", m_user, exp_q[0].u);
        check("m_last", m_last, exp_q[0].l);
      end
      if (clken && m_valid && m_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pop++;
      end
      if (clken && s_valid && s_ready) begin
        b.d = s_data;
        b.u = '0;
        if (p == 1)              b.u[2] = 1'b1;
        else if (acc % p == p-1) b.u[1] = 1'b1;
        else                     b.u[0] = 1'b1;
        b.l = (acc == total - 1);
        exp_q.push_back(b);
        acc++;
      end
      if (pop == total) begin
        if (mode == 0) check("cycles_full_rate", cyc, total);
        if (mode == 3) check("cycles_clken", cyc, total + 5);
        done = 1;
      end
      if (abort_at != 0 && acc == abort_at) done = 1;
      if (cyc > 500) begin
        check("timeout", 0, 1);
        done = 1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!done) drive(mode, cyc);
    end
    s_valid = 1'b0;
    clken   = 1'b1;
    if (abort_at == 0) begin
      @(negedge clk);
      check("busy_after", busy, 0);
      check("cfg_ready_after", cfg_ready, 1);
      check("s_ready_idle", s_ready, 0);
    end
  endtask

  task automatic bad_cfg(input int p, input int w);
    @(negedge clk);
    cfg_pool_len = PLW'(p);
    cfg_windows  = 16'(w);
    cfg_valid    = 1'b1;
    s_valid      = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    check("err_cfg_set", err_cfg, 1);
    check("bad_busy", busy, 0);
    check("bad_cfg_ready", cfg_ready, 1);
    check("bad_s_ready", s_ready, 0);
    s_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; clken = 1'b1; cfg_valid = 1'b0; cfg_pool_len = '0;
    cfg_windows = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #13;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_user", m_user, 0);
    check("rst_m_data", m_data, 0);
    check("rst_err_cfg", err_cfg, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    #10 resetn = 1'b1;

    run_layer(2, 3, 0, 0);
    run_layer(1, 4, 0, 0);
    run_layer(3, 2, 1, 0);
    run_layer(3, 3, 3, 0);
    run_layer(POOL_MAX, 2, 0, 0);
    repeat (4) run_layer($urandom_range(1, POOL_MAX), $urandom_range(1, 4), 2, 0);
    check("err_cfg_clear", err_cfg, 0);

    bad_cfg(0, 5);
    bad_cfg(POOL_MAX + 1, 5);
    bad_cfg(2, 0);

    run_layer(2, 4, 0, 3);
    resetn = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_cfg_ready", cfg_ready, 1);
    check("arst_m_user", m_user, 0);
    check("arst_m_last", m_last, 0);
    check("arst_err_cfg", err_cfg, 0);
    @(negedge clk);
    resetn = 1'b1;
    run_layer(2, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
